mem_port_arbiter: RTL and testbench

//  Shares the single line-wide memory port between the ICache (read-only client 0) and the DCache
//  (read/write client 1). Round-robin arbitration; a grant is held for one whole transaction.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/rv32_types_pkg.sv | 7 +
 rtl/rr_picker2.sv | 16 +
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// MemPortArbiterTypes: state and client encodings for mem_port_arbiter.
package MemPortArbiterTypes;

    typedef enum logic [1:0] {
        Idle   = 2'd0,
        GrantI = 2'd1,
        GrantD = 2'd2
    } ArbiterState;

    // Encoding doubles as the bit index of the client in a request vector.
    typedef enum logic {
        Client_ICache = 1'b0,
        Client_DCache = 1'b1
    } ArbiterClient;

    localparam int unsigned PERF_COUNT_WIDTH = 32;

endpackage : MemPortArbiterTypes

// File: rtl/rv32_types_pkg.sv
// Rv32Types: shared RV32 address types used across the memory subsystem.
package Rv32Types;

    // Physical address as seen by the caches and the memory bridge.
    typedef logic [31:0] paddr_t;

endpackage : Rv32Types

// File: rtl/rr_picker2.sv
// rr_picker2: combinational two-way round-robin pick. With a single requester
// that requester wins; on a tie the client that was not served last wins.
module rr_picker2
    import MemPortArbiterTypes::*;
(
    input  logic [1:0]   i_req,
    input  ArbiterClient i_last,
    output logic         o_valid,
    output ArbiterClient o_grant
);

    assign o_valid = |i_req;
    assign o_grant = (i_req[1] && (!i_req[0] || (i_last == Client_ICache)))
                   ? Client_DCache : Client_ICache;

endmodule : rr_picker2

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single line-wide memory port between the
// ICache (read-only) and the DCache (read/write). Round-robin arbitration,
// grant held for one whole transaction, one Idle cycle between grants.
// Optional build macro MEM_PORT_ARBITER_PERF_COUNTER_EN adds the
// perfGrantI / perfGrantD / perfConflict counter outputs.
module mem_port_arbiter
    import Rv32Types::*;
    import MemPortArbiterTypes::*;
#(
    parameter int LINE_WIDTH = 64
)
(
    input  logic                  clk,
    input  logic                  rst,
    // ICache side
    input  paddr_t                iAddr,
    input  logic                  iReadEnable,
    output logic                  iReadDone,
    output logic [LINE_WIDTH-1:0] iReadValue,
    // DCache side
    input  paddr_t                dAddr,
    input  logic                  dReadEnable,
    input  logic                  dWriteEnable,
    input  logic [LINE_WIDTH-1:0] dWriteValue,
    output logic                  dReadDone,
    output logic                  dWriteDone,
    output logic [LINE_WIDTH-1:0] dReadValue,
    // Memory side
    output paddr_t                memAddr,
    output logic                  memReadEnable,
    output logic                  memWriteEnable,
    output logic [LINE_WIDTH-1:0] memWriteValue,
    input  logic                  memReadDone,
    input  logic                  memWriteDone,
    input  logic [LINE_WIDTH-1:0] memReadValue
`ifdef MEM_PORT_ARBITER_PERF_COUNTER_EN
    ,
    output logic [PERF_COUNT_WIDTH-1:0] perfGrantI,
    output logic [PERF_COUNT_WIDTH-1:0] perfGrantD,
    output logic [PERF_COUNT_WIDTH-1:0] perfConflict
`endif
);

    ArbiterState  r_state;
    ArbiterClient r_last_grant;

    logic [1:0]   w_req;
    logic         w_pick_valid;
    ArbiterClient w_pick_client;
    logic         w_mem_done;
    logic         w_d_active;

    assign w_d_active = dReadEnable | dWriteEnable;
    assign w_req      = {w_d_active, iReadEnable};
    assign w_mem_done = memReadDone | memWriteDone;

    rr_picker2 u_picker (
        .i_req   (w_req),
        .i_last  (r_last_grant),
        .o_valid (w_pick_valid),
        .o_grant (w_pick_client)
    );

    // Arbitration FSM: grant from Idle, release on done or on client abort.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= Idle;
            r_last_grant <= Client_ICache;
        end else begin
            unique case (r_state)
                Idle: begin
                    if (w_pick_valid) begin
                        r_state <= (w_pick_client == Client_DCache) ? GrantD : GrantI;
                    end
                end
                GrantI: begin
                    if (w_mem_done) begin
                        r_state      <= Idle;
                        r_last_grant <= Client_ICache;
                    end else if (!iReadEnable) begin
                        r_state <= Idle;
                    end
                end
                GrantD: begin
                    if (w_mem_done) begin
                        r_state      <= Idle;
                        r_last_grant <= Client_DCache;
                    end else if (!w_d_active) begin
                        r_state <= Idle;
                    end
                end
                default: r_state <= Idle;
            endcase
        end
    end

    // Route the granted client to memory and memory responses back to it only.
    // NOTE: every output gets a zero default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        memAddr        = '0;
        memReadEnable  = 1'b0;
        memWriteEnable = 1'b0;
        memWriteValue  = '0;
        iReadDone      = 1'b0;
        iReadValue     = '0;
        dReadDone      = 1'b0;
        dWriteDone     = 1'b0;
        dReadValue     = '0;
        unique case (r_state)
            GrantI: begin
                memAddr       = iAddr;
                memReadEnable = iReadEnable;
                iReadDone     = memReadDone;
                iReadValue    = memReadValue;
            end
            GrantD: begin
                memAddr        = dAddr;
                memReadEnable  = dReadEnable;
                memWriteEnable = dWriteEnable;
                memWriteValue  = dWriteValue;
                dReadDone      = memReadDone;
                dWriteDone     = memWriteDone;
                dReadValue     = memReadValue;
            end
            default: ;
        endcase
    end

    // A DCache request is either a read or a write, never both at once.
    a_d_rw_exclusive : assert property (
        @(posedge clk) disable iff (!rst) !(dReadEnable && dWriteEnable)
    );

`ifdef MEM_PORT_ARBITER_PERF_COUNTER_EN
    logic [PERF_COUNT_WIDTH-1:0] r_perf_grant_i;
    logic [PERF_COUNT_WIDTH-1:0] r_perf_grant_d;
    logic [PERF_COUNT_WIDTH-1:0] r_perf_conflict;

    // Count grants per client and Idle cycles with both clients requesting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_grant_i  <= '0;
            r_perf_grant_d  <= '0;
            r_perf_conflict <= '0;
        end else if (r_state == Idle) begin
            if (w_pick_valid && (w_pick_client == Client_ICache)) begin
                r_perf_grant_i <= r_perf_grant_i + 1'b1;
            end
            if (w_pick_valid && (w_pick_client == Client_DCache)) begin
                r_perf_grant_d <= r_perf_grant_d + 1'b1;
            end
            if (&w_req) begin
                r_perf_conflict <= r_perf_conflict + 1'b1;
            end
        end
    end

    assign perfGrantI   = r_perf_grant_i;
    assign perfGrantD   = r_perf_grant_d;
    assign perfConflict = r_perf_conflict;
`endif

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the two-client round-robin port.
module tb_mem_port_arbiter;
    import Rv32Types::*;

    localparam int LW = 64;

    logic          clk = 1'b0;
    logic          rst;
    paddr_t        iAddr, dAddr, memAddr;
    logic          iReadEnable, iReadDone;
    logic [LW-1:0] iReadValue;
    logic          dReadEnable, dWriteEnable, dReadDone, dWriteDone;
    logic [LW-1:0] dWriteValue, dReadValue;
    logic          memReadEnable, memWriteEnable, memReadDone, memWriteDone;
    logic [LW-1:0] memWriteValue, memReadValue;
`ifdef MEM_PORT_ARBITER_PERF_COUNTER_EN
    logic [31:0]   perfGrantI, perfGrantD, perfConflict;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // All outputs packed: addr, re, we, wval, iDone, iVal, dRDone, dWDone, dVal
    logic [228:0] w_all_out;
    assign w_all_out = {memAddr, memReadEnable, memWriteEnable, memWriteValue,
                        iReadDone, iReadValue, dReadDone, dWriteDone, dReadValue};

    always #5 clk = ~clk;

    mem_port_arbiter #(.LINE_WIDTH(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .iAddr          (iAddr),
        .iReadEnable    (iReadEnable),
        .iReadDone      (iReadDone),
        .iReadValue     (iReadValue),
        .dAddr          (dAddr),
        .dReadEnable    (dReadEnable),
        .dWriteEnable   (dWriteEnable),
        .dWriteValue    (dWriteValue),
        .dReadDone      (dReadDone),
        .dWriteDone     (dWriteDone),
        .dReadValue     (dReadValue),
        .memAddr        (memAddr),
        .memReadEnable  (memReadEnable),
        .memWriteEnable (memWriteEnable),
        .memWriteValue  (memWriteValue),
        .memReadDone    (memReadDone),
        .memWriteDone   (memWriteDone),
        .memReadValue   (memReadValue)
`ifdef MEM_PORT_ARBITER_PERF_COUNTER_EN
        ,
        .perfGrantI     (perfGrantI),
        .perfGrantD     (perfGrantD),
        .perfConflict   (perfConflict)
`endif
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        iAddr = '0; iReadEnable = 1'b0;
        dAddr = '0; dReadEnable = 1'b0; dWriteEnable = 1'b0; dWriteValue = '0;
        memReadDone = 1'b0; memWriteDone = 1'b0; memReadValue = '0;
    endtask

    // Ends on a falling edge with reset just released and all inputs idle.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        iReadEnable = 1'b1; iAddr = 32'h0000_1000;
        dReadEnable = 1'b1; dAddr = 32'h0000_2000;
        memReadDone = 1'b1; memReadValue = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        #1;
        n_checks++;
        if (w_all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", w_all_out);
        end
        tick(); tick();
        #1;
        n_checks++;
        if (w_all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_held: got %h expected 0", w_all_out);
        end
        do_reset();
    endtask

    task automatic test_single_iread();
        do_reset();
        iAddr = 32'h0000_1000; iReadEnable = 1'b1;
        memReadValue = 64'hDEAD_BEEF_0123_4567;
        #1;
        n_checks++;
        if (memReadEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL sir_latency: memReadEnable=%b expected 0", memReadEnable);
        end
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) memReadDone = 1'b1;
            #1;
            n_checks++;
            if (memReadEnable !== 1'b1 || memAddr !== 32'h0000_1000) begin
                n_fail++;
                $display("FAIL sir_request c%0d: re=%b addr=%h expected 1 00001000", c, memReadEnable, memAddr);
            end
            n_checks++;
            if (iReadDone !== (c == 3) || dReadDone !== 1'b0) begin
                n_fail++;
                $display("FAIL sir_done c%0d: iDone=%b dDone=%b expected %0d 0", c, iReadDone, dReadDone, c == 3);
            end
            if (c == 3) begin
                n_checks++;
                if (iReadValue !== 64'hDEAD_BEEF_0123_4567 || dReadValue !== '0) begin
                    n_fail++;
                    $display("FAIL sir_value: iVal=%h dVal=%h expected deadbeef01234567 0", iReadValue, dReadValue);
                end
            end
        end
        tick();
        memReadDone = 1'b0; iReadEnable = 1'b0;
        #1;
        n_checks++;
        if (w_all_out !== '0) begin
            n_fail++;
            $display("FAIL sir_idle_after: got %h expected 0", w_all_out);
        end
    endtask

    task automatic test_tie_first();
        do_reset();
        iAddr = 32'h0000_1040; iReadEnable = 1'b1;
        dAddr = 32'h0000_3000; dWriteValue = 64'h1122_3344_5566_7788; dWriteEnable = 1'b1;
        #1;
        n_checks++;
        if (memReadEnable !== 1'b0 || memWriteEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_arb_cycle: re=%b we=%b expected 0 0", memReadEnable, memWriteEnable);
        end
        tick();
        #1;
        n_checks++;
        if ({memWriteEnable, memReadEnable, memAddr, memWriteValue} !==
            {1'b1, 1'b0, 32'h0000_3000, 64'h1122_3344_5566_7788}) begin
            n_fail++;
            $display("FAIL tie_d_first: we=%b re=%b addr=%h wv=%h expected 1 0 00003000 1122334455667788",
                     memWriteEnable, memReadEnable, memAddr, memWriteValue);
        end
        memWriteDone = 1'b1;
        #1;
        n_checks++;
        if (dWriteDone !== 1'b1 || iReadDone !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_d_done: dWDone=%b iDone=%b expected 1 0", dWriteDone, iReadDone);
        end
        tick();
        memWriteDone = 1'b0; dWriteEnable = 1'b0;
        #1;
        n_checks++;
        if (memReadEnable !== 1'b0 || memWriteEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_idle_gap: re=%b we=%b expected 0 0", memReadEnable, memWriteEnable);
        end
        tick();
        #1;
        n_checks++;
        if (memReadEnable !== 1'b1 || memAddr !== 32'h0000_1040) begin
            n_fail++;
            $display("FAIL tie_i_second: re=%b addr=%h expected 1 00001040", memReadEnable, memAddr);
        end
        memReadDone = 1'b1; memReadValue = 64'h0F0F_0F0F_0F0F_0F0F;
        #1;
        n_checks++;
        if (iReadDone !== 1'b1 || iReadValue !== 64'h0F0F_0F0F_0F0F_0F0F) begin
            n_fail++;
            $display("FAIL tie_i_done: iDone=%b iVal=%h expected 1 0f0f0f0f0f0f0f0f", iReadDone, iReadValue);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_dwrite_blocks_i();
        do_reset();
        iAddr = 32'h0000_1000; iReadEnable = 1'b1;
        dAddr = 32'h0000_2000; dWriteValue = {8{8'hAA}}; dWriteEnable = 1'b1;
        memReadValue = 64'h5555_5555_5555_5555;
        tick();
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) memWriteDone = 1'b1;
            #1;
            n_checks++;
            if ({memWriteEnable, memReadEnable, memAddr, memWriteValue} !==
                {1'b1, 1'b0, 32'h0000_2000, {8{8'hAA}}}) begin
                n_fail++;
                $display("FAIL dwr_request c%0d: we=%b re=%b addr=%h wv=%h expected 1 0 00002000 aaaaaaaaaaaaaaaa",
                         c, memWriteEnable, memReadEnable, memAddr, memWriteValue);
            end
            n_checks++;
            if (iReadDone !== 1'b0 || iReadValue !== '0 || dWriteDone !== (c == 4)) begin
                n_fail++;
                $display("FAIL dwr_isolation c%0d: iDone=%b iVal=%h dWDone=%b expected 0 0 %0d",
                         c, iReadDone, iReadValue, dWriteDone, c == 4);
            end
            tick();
        end
        memWriteDone = 1'b0; dWriteEnable = 1'b0;
        tick();
        #1;
        n_checks++;
        if (memReadEnable !== 1'b1 || memAddr !== 32'h0000_1000) begin
            n_fail++;
            $display("FAIL dwr_i_after: re=%b addr=%h expected 1 00001000", memReadEnable, memAddr);
        end
        memReadDone = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_alternation();
        localparam paddr_t I_A = 32'h0000_0100;
        localparam paddr_t D_A = 32'h0000_0200;
        int exp_cl, cur, cnt, lat, idle_run, ntx;
        logic [LW-1:0] v;
        do_reset();
        iAddr = I_A; dAddr = D_A;
        iReadEnable = 1'b1; dReadEnable = 1'b1;
        exp_cl = 2; cnt = 0; lat = 1; idle_run = 0; ntx = 0; cur = 0;
        for (int cyc = 0; cyc < 200 && ntx < 10; cyc++) begin
            memReadDone = 1'b0;
            #1;
            if (memReadEnable === 1'b1) begin
                cur = (memAddr === D_A) ? 2 : 1;
                if (cnt == 0) begin
                    n_checks++;
                    if (cur != exp_cl || idle_run != 1) begin
                        n_fail++;
                        $display("FAIL alt_grant tx%0d: client=%0d gap=%0d expected %0d 1", ntx, cur, idle_run, exp_cl);
                    end
                    lat = $urandom_range(1, 3);
                end
                cnt++;
                if (cnt == lat) begin
                    v = {$urandom, $urandom};
                    memReadValue = v; memReadDone = 1'b1;
                    #1;
                    n_checks++;
                    if ((cur == 1 && {iReadDone, dReadDone, iReadValue, dReadValue} !== {2'b10, v, 64'h0}) ||
                        (cur == 2 && {iReadDone, dReadDone, iReadValue, dReadValue} !== {2'b01, 64'h0, v})) begin
                        n_fail++;
                        $display("FAIL alt_done tx%0d client=%0d: iDone=%b dDone=%b iVal=%h dVal=%h value %h",
                                 ntx, cur, iReadDone, dReadDone, iReadValue, dReadValue, v);
                    end
                    ntx++; exp_cl = 3 - cur; cnt = 0; idle_run = 0;
                end
            end else begin
                idle_run++;
            end
            tick();
        end
        memReadDone = 1'b0; iReadEnable = 1'b0; dReadEnable = 1'b0;
        n_checks++;
        if (ntx != 10) begin
            n_fail++;
            $display("FAIL alt_timeout: completed %0d transactions expected 10", ntx);
        end
`ifdef MEM_PORT_ARBITER_PERF_COUNTER_EN
        #1;
        n_checks++;
        if (perfGrantI !== 32'd5 || perfGrantD !== 32'd5 || perfConflict !== 32'd10) begin
            n_fail++;
            $display("FAIL alt_perf: I=%0d D=%0d conflict=%0d expected 5 5 10", perfGrantI, perfGrantD, perfConflict);
        end
`endif
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid_txn();
        do_reset();
        dAddr = 32'h0000_4000; dReadEnable = 1'b1;
        tick();
        #1;
        n_checks++;
        if (memReadEnable !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: memReadEnable=%b expected 1", memReadEnable);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (memReadEnable !== 1'b0 || memAddr !== '0) begin
            n_fail++;
            $display("FAIL rst_async_drop: re=%b addr=%h expected 0 0", memReadEnable, memAddr);
        end
        dReadEnable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        #1;
        n_checks++;
        if (w_all_out !== '0) begin
            n_fail++;
            $display("FAIL rst_idle_after: got %h expected 0", w_all_out);
        end
        iAddr = 32'h0000_1000; iReadEnable = 1'b1; dReadEnable = 1'b1;
        tick();
        #1;
        n_checks++;
        if (memReadEnable !== 1'b1 || memAddr !== 32'h0000_4000) begin
            n_fail++;
            $display("FAIL rst_tie_d: re=%b addr=%h expected 1 00004000", memReadEnable, memAddr);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_abort();
        do_reset();
        dAddr = 32'h0000_5000; dWriteEnable = 1'b1;
        tick();
        memWriteDone = 1'b1;
        tick();
        memWriteDone = 1'b0; dWriteEnable = 1'b0;
        iAddr = 32'h0000_6000; iReadEnable = 1'b1;
        tick();
        #1;
        n_checks++;
        if (memReadEnable !== 1'b1 || memAddr !== 32'h0000_6000) begin
            n_fail++;
            $display("FAIL abort_grant: re=%b addr=%h expected 1 00006000", memReadEnable, memAddr);
        end
        iReadEnable = 1'b0;
        #1;
        n_checks++;
        if (memReadEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_drop: memReadEnable=%b expected 0", memReadEnable);
        end
        tick();
        #1;
        n_checks++;
        if (w_all_out !== '0) begin
            n_fail++;
            $display("FAIL abort_idle: got %h expected 0", w_all_out);
        end
        // Last completed grant was D; the aborted I grant must not count.
        iReadEnable = 1'b1; dReadEnable = 1'b1;
        tick();
        #1;
        n_checks++;
        if (memReadEnable !== 1'b1 || memAddr !== 32'h0000_6000) begin
            n_fail++;
            $display("FAIL abort_rr_keep: re=%b addr=%h expected 1 00006000", memReadEnable, memAddr);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        int owner, last, mem_cnt;
        bit i_pend, d_pend, i_fin, d_fin, d_is_wr, req_i, req_d;
        logic [228:0] exp;
        do_reset();
        owner = 0; last = 1; mem_cnt = 0;
        i_pend = 0; d_pend = 0; i_fin = 0; d_fin = 0; d_is_wr = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (i_fin) begin
                i_pend = 0; i_fin = 0;
            end else if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1; iAddr = $urandom;
            end else if (i_pend && owner == 1 && $urandom_range(0, 15) == 0) begin
                i_pend = 0;
            end
            if (d_fin) begin
                d_pend = 0; d_fin = 0;
            end else if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; d_is_wr = $urandom_range(0, 1) == 1;
                dAddr = $urandom; dWriteValue = {$urandom, $urandom};
            end else if (d_pend && owner == 2 && $urandom_range(0, 15) == 0) begin
                d_pend = 0;
            end
            iReadEnable  = i_pend;
            dReadEnable  = d_pend && !d_is_wr;
            dWriteEnable = d_pend && d_is_wr;

            memReadDone = 1'b0; memWriteDone = 1'b0;
            memReadValue = {$urandom, $urandom};
            if (owner == 1 && i_pend) begin
                if (mem_cnt == 0) begin memReadDone = 1'b1; i_fin = 1; end
                else mem_cnt--;
            end else if (owner == 2 && d_pend) begin
                if (mem_cnt == 0) begin
                    memReadDone = !d_is_wr; memWriteDone = d_is_wr; d_fin = 1;
                end else mem_cnt--;
            end

            exp = '0;
            if (owner == 1)
                exp = {iAddr, i_pend, 1'b0, 64'h0, memReadDone, memReadValue, 2'b00, 64'h0};
            else if (owner == 2)
                exp = {dAddr, d_pend && !d_is_wr, d_pend && d_is_wr, dWriteValue,
                       1'b0, 64'h0, memReadDone, memWriteDone, memReadValue};
            #1;
            n_checks++;
            if (w_all_out !== exp) begin
                n_fail++;
                $display("FAIL rand_cycle%0d owner=%0d: got %h expected %h", cyc, owner, w_all_out, exp);
            end

            req_i = i_pend; req_d = d_pend;
            if (owner == 0) begin
                if (req_i && req_d) owner = (last == 1) ? 2 : 1;
                else if (req_i)     owner = 1;
                else if (req_d)     owner = 2;
                if (owner != 0) mem_cnt = $urandom_range(0, 3);
            end else if (memReadDone || memWriteDone) begin
                last = owner; owner = 0;
            end else if ((owner == 1 && !req_i) || (owner == 2 && !req_d)) begin
                owner = 0;
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1'b0;
        test_reset();
        test_single_iread();
        test_tie_first();
        test_dwrite_blocks_i();
        test_alternation();
        test_reset_mid_txn();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_port_arbiter
